// File: rtl/tbird_light_controller.sv
// Thunderbird tail-light sequencer: arbitrates turn/hazard requests, steps the winning lamp
// pattern every TICK_DIV clocks and re-arbitrates only at step 0. Optional brake overlay: TBIRD_BRAKE_EN.
module tbird_light_controller #(
    parameter int TICK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
    input  logic       brake_req,
    output logic [7:0] t_output,
    output logic [1:0] mode,
    output logic [2:0] step,
    output logic       busy
);

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_e;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    mode_e       r_mode;
    logic [2:0]  r_step;
    logic [7:0]  r_tick;
    logic [7:0]  r_t_output;
    logic        r_busy;

    mode_e       w_winner;
    mode_e       w_next_mode;
    logic [2:0]  w_next_step;
    logic [7:0]  w_next_tick;
    logic [2:0]  w_last_step;
    logic        w_tick_done;
    logic [7:0]  w_pattern;
    logic [7:0]  w_overlay;

    // Lamp image for a given mode/step; turn groups light from the innermost lamp outward.
    function automatic logic [7:0] pattern_of(input mode_e m, input logic [2:0] s);
        logic [3:0] ramp;
        case (s)
            3'd0:    ramp = 4'b0000;
            3'd1:    ramp = 4'b0001;
            3'd2:    ramp = 4'b0011;
            3'd3:    ramp = 4'b0111;
            default: ramp = 4'b1111;
        endcase
        case (m)
            MODE_LEFT:   pattern_of = {ramp, 4'h0};
            MODE_RIGHT:  pattern_of = {4'h0, ramp[0], ramp[1], ramp[2], ramp[3]};
            MODE_HAZARD: pattern_of = (s == 3'd1) ? 8'hFF : 8'h00;
            default:     pattern_of = 8'h00;
        endcase
    endfunction

    always_comb begin
        if (hazard_req || (left_req && right_req)) begin
            w_winner = MODE_HAZARD;
        end else if (left_req) begin
            w_winner = MODE_LEFT;
        end else if (right_req) begin
            w_winner = MODE_RIGHT;
        end else begin
            w_winner = MODE_IDLE;
        end
    end

    assign w_last_step = (r_mode == MODE_HAZARD) ? 3'd1 : 3'd4;
    assign w_tick_done = (r_tick == TICK_LAST);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_next_mode = r_mode;
        w_next_step = r_step;
        w_next_tick = r_tick;
        if (r_mode == MODE_IDLE) begin
            if (w_winner != MODE_IDLE) begin
                w_next_mode = w_winner;
                w_next_step = 3'd1;
                w_next_tick = 8'd0;
            end
        end else if (w_tick_done) begin
            w_next_tick = 8'd0;
            if (r_step == w_last_step) begin
                w_next_step = 3'd0;
            end else if (r_step == 3'd0) begin
                // Sequence boundary: the only point where a new request can take the lamps.
                w_next_mode = w_winner;
                w_next_step = (w_winner == MODE_IDLE) ? 3'd0 : 3'd1;
            end else begin
                w_next_step = r_step + 3'd1;
            end
        end else begin
            w_next_tick = r_tick + 8'd1;
        end
    end

    assign w_pattern = pattern_of(w_next_mode, w_next_step);

`ifdef TBIRD_BRAKE_EN
    always_comb begin
        w_overlay = 8'h00;
        if (brake_req) begin
            case (w_next_mode)
                MODE_IDLE:  w_overlay = 8'hFF;
                MODE_LEFT:  w_overlay = 8'h0F;
                MODE_RIGHT: w_overlay = 8'hF0;
                default:    w_overlay = 8'h00;
            endcase
        end
    end
`else
    logic w_unused_brake;
    assign w_unused_brake = brake_req;
    assign w_overlay      = 8'h00;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode     <= MODE_IDLE;
            r_step     <= 3'd0;
            r_tick     <= 8'd0;
            r_t_output <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_mode     <= w_next_mode;
            r_step     <= w_next_step;
            r_tick     <= w_next_tick;
            r_t_output <= w_pattern | w_overlay;
            r_busy     <= (w_next_mode != MODE_IDLE);
        end
    end

    assign t_output = r_t_output;
    assign mode     = r_mode;
    assign step     = r_step;
    assign busy     = r_busy;

endmodule

// File: doc/tbird_light_controller.md
# tbird_light_controller

Sequencing and arbitration controller for the Thunderbird tail-light datapath. It takes left-turn, right-turn, hazard and brake requests and decides which lamp pattern owns the 8 lamps. It steps the chosen pattern at a programmable animation rate and switches modes only at sequence boundaries, so a pattern is never cut off mid-sweep. It sits between the switch/request inputs and the lamp drivers, and replaces ad-hoc per-switch sequencing.

## Interface
- TICK_DIV, 4: clock cycles each animation step is held; legal range 1..255.
- clock  in  1  rising-edge system clock.
- reset_n  in  1  asynchronous, active-low reset.
- left_req  in  1  left-turn request, level.
- right_req  in  1  right-turn request, level.
- hazard_req  in  1  hazard request, level.
- brake_req  in  1  brake request, level; used only with TBIRD_BRAKE_EN.
- t_output  out  8  registered lamp drive.
  - [7:4] is the left group, with bit 4 innermost.
  - [3:0] is the right group, with bit 3 innermost.
- mode  out  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
- step  out  3  current step index.
- busy  out  1  high when mode != IDLE.

## Operation
- **Arbitration winner**, evaluated from the current request levels:
  - HAZARD if hazard_req, or if left_req and right_req are both high;
  - else LEFT if left_req;
  - else RIGHT if right_req;
  - else IDLE.
- **LEFT pattern:** 5 steps.
  - Step 0: [7:4]=0000.
  - Steps 1–4: 0001, 0011, 0111, 1111.
  - Right group is 0000 throughout.
- **RIGHT pattern:** mirror of LEFT on [3:0]: 0000, 1000, 1100, 1110, 1111. Left group is 0000.
- **HAZARD pattern:**
  - Step 0: 8'h00.
  - Step 1: 8'hFF.
- **IDLE:** t_output=8'h00 and step=0.
- **Tick counter** (8 bits):
  - Cleared on every mode entry.
  - Increments each clock while mode != IDLE.
  - On reaching TICK_DIV-1: clears and advances the step.
- **Step advance:**
  - From the last step (4 for turn, 1 for hazard) go to step 0 of the same mode.
  - From step 0, re-arbitrate (this is the sequence boundary):
    - winner not IDLE: enter the winner at step 1; this may be the same mode;
    - winner IDLE: go to IDLE.
- **From IDLE:** re-arbitrate every clock. A non-IDLE winner is entered at step 1 on that edge.
- **Request changes mid-sequence** (drop, add, or switch) are ignored until the boundary.
  - Example: in LEFT, dropping left_req and asserting right_req lets LEFT finish through step 0, then RIGHT enters.
- **Reset:** asynchronous. It immediately forces all of the following to 0:
  - mode=IDLE and step=0;
  - tick counter;
  - t_output=8'h00;
  - busy=0.
  
  Reset mid-sequence abandons the sequence. After release, arbitration restarts from IDLE.

## Timing
- t_output, mode, step and busy are all registered and change only on the rising edge of clock, apart from the asynchronous reset.
- Entry latency: a request sampled high at edge N in IDLE gives the step-1 pattern after edge N.
- Every step is held exactly TICK_DIV cycles.
- Full turn cycle is 5·TICK_DIV cycles; full hazard cycle is 2·TICK_DIV cycles.
- Returning to IDLE after the request drops takes at most (5·TICK_DIV) cycles for a turn, or 2·TICK_DIV for hazard, counted from the drop.
- TICK_DIV=1: the step advances every clock. No stall cycles are allowed at the boundary; step 0 expiry and the entry to step 1 happen on the same edge.
- Simultaneous left_req and right_req at a boundary or in IDLE resolve to HAZARD.

## Configuration
- **TBIRD_BRAKE_EN defined:** brake_req overlays the registered output, sampled on the same edge as the pattern update (1-cycle latency):
  - IDLE: 8'hFF.
  - LEFT: [3:0]=1111.
  - RIGHT: [7:4]=1111.
  - HAZARD: no effect.
  
  Brake never changes mode, step or arbitration.
- **TBIRD_BRAKE_EN undefined:** brake_req is ignored; the port remains present and t_output is the pure pattern.

## Test plan
- **Reset and IDLE:** hold reset_n=0, then release with no requests → t_output=00, mode=0, busy=0 indefinitely.
- **LEFT sequence**, TICK_DIV=4, left_req held:
  - t_output steps 10, 30, 70, F0, 00, each held 4 cycles, then repeats from 10;
  - left_req dropped at step 2 → sequence finishes through 00, then mode=0.
- **Switch at boundary:** in RIGHT, assert left_req and drop right_req at step 1 → 08, 0C, 0E, 0F, 00 complete, then 10 appears with mode=1.
- **Hazard arbitration:** left_req=right_req=1 from IDLE → mode=3, t_output alternates FF/00 every 4 cycles; step never exceeds 1.
- **Mid-operation reset:** pulse reset_n low for 3 ns, not aligned to clock, during LEFT step 3 → outputs go to 0 immediately; with left_req still high, 10 appears one edge after release.
- **Brake (TBIRD_BRAKE_EN):**
  - brake_req in IDLE → FF one edge later;
  - brake_req during LEFT step 2 → 3F;
  - brake_req during HAZARD → pattern unchanged.
  
  Without the macro, the same stimulus gives 00 and 30.
